decode_chk: RTL and testbench

//  Stream sink/checker directly downstream of the decode traffic generator. Accepts 64-bit bursts on a

---
 rtl/cryp_tg_pkg.sv | 22 ++
 rtl/decode_chk_lfsr.sv | 23 ++
 rtl/decode_chk.sv | 144 ++++++++++++++
 tb/tb_decode_chk.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cryp_tg_pkg.sv
// Shared definitions for the cryp traffic generator / checker pair.
// Holds the stream data width, checker state encoding and the LFSR tap
// mask so decode_tg and decode_chk agree on the stream format.
package cryp_tg_pkg;

  localparam int DATA_W = 64;

  // Checker state: SYNC means no expected value is known yet.
  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } chk_state_e;

  // Fibonacci taps 16,14,13,11 mapped onto bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // XOR of the tapped bits, shifted in at bit 0.
  function automatic logic lfsr_feedback(input logic [15:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/decode_chk_lfsr.sv
// 16-bit Fibonacci LFSR used to generate pseudo-random backpressure for
// decode_chk. Loads SEED in reset and advances once per enabled cycle.
module decode_chk_lfsr
  import cryp_tg_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  output logic [15:0] state
);

  // Shift register: load seed in reset, otherwise shift the feedback in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEED;
    end else if (step) begin
      state <= {state[14:0], lfsr_feedback(state)};
    end
  end

endmodule

// File: rtl/decode_chk.sv
// Stream sink/checker for the decode traffic generator.
// Accepts 64-bit bursts on valid/ready/last, checks that the payload
// increments by one per accepted beat (across bursts) and that each burst
// length lies within [MIN_BEATS, MAX_BEATS]. Counts bursts and errors and
// captures the first payload mismatch.
// Optional feature: define DECODE_CHK_BP_EN to drive ready from an LFSR
// (pseudo-random backpressure); otherwise ready is high outside reset.
module decode_chk
  import cryp_tg_pkg::*;
#(
  parameter int          MIN_BEATS = 1,
  parameter int          MAX_BEATS = 32,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_axi_valid,
  input  logic [DATA_W-1:0] s_axi_data,
  input  logic              s_axi_last,
  output logic              s_axi_ready,
  output logic [CNT_W-1:0]  burst_count,
  output logic [CNT_W-1:0]  error_count,
  output logic              err_data,
  output logic              err_len,
  output logic [DATA_W-1:0] err_expected,
  output logic [DATA_W-1:0] err_actual
);

  // Beat counter saturates at MAX_BEATS+1, so it needs room for that value.
  localparam int BW = $clog2(MAX_BEATS + 2);
  localparam logic [BW-1:0] MAX_CNT = BW'(MAX_BEATS);
  localparam logic [BW-1:0] OVR_CNT = BW'(MAX_BEATS + 1);

  chk_state_e        state;
  chk_state_e        state_next;
  logic [DATA_W-1:0] exp_data;
  logic [BW-1:0]     beat_cnt;
  logic [BW-1:0]     beat_next;
  logic              ready_next;
  logic              accept;
  logic              data_err;
  logic              len_err;
  logic [CNT_W:0]    err_sum;
  logic [CNT_W-1:0]  error_next;
  logic [CNT_W-1:0]  burst_next;

`ifdef DECODE_CHK_BP_EN
  logic [15:0] lfsr_state;

  decode_chk_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .step (1'b1),
    .state(lfsr_state)
  );

  assign ready_next = lfsr_state[0] | lfsr_state[1];
`else
  assign ready_next = 1'b1;
`endif

  // Ready is registered; it is held low in reset and rises the cycle after.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_axi_ready <= 1'b0;
    end else begin
      s_axi_ready <= ready_next;
    end
  end

  // Evaluate the current beat: data check, length check, next counter values.
  always_comb begin
    accept     = s_axi_valid & s_axi_ready;
    data_err   = 1'b0;
    len_err    = 1'b0;
    state_next = state;
    beat_next  = beat_cnt;
    burst_next = burst_count;
    if (accept) begin
      state_next = ST_RUN;
      data_err   = (state == ST_RUN) && (s_axi_data != exp_data);
      if (s_axi_last) begin
        // beat_cnt == MAX_CNT means this last beat is beat MAX+1 and the
        // overrun was not yet flagged; at OVR_CNT it already was.
        len_err   = ((int'(beat_cnt) + 1) < MIN_BEATS) || (beat_cnt == MAX_CNT);
        beat_next = '0;
        if (burst_count != '1) begin
          burst_next = burst_count + 1'b1;
        end
      end else begin
        len_err = (beat_cnt == MAX_CNT);
        if (beat_cnt != OVR_CNT) begin
          beat_next = beat_cnt + 1'b1;
        end
      end
    end
    err_sum    = {1'b0, error_count} + (CNT_W + 1)'(data_err) + (CNT_W + 1)'(len_err);
    error_next = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
  end

  // Checker state register: SYNC until the first accepted beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_SYNC;
    end else begin
      state <= state_next;
    end
  end

  // Expected value, counters, sticky flags and first-error capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_data     <= '0;
      beat_cnt     <= '0;
      burst_count  <= '0;
      error_count  <= '0;
      err_data     <= 1'b0;
      err_len      <= 1'b0;
      err_expected <= '0;
      err_actual   <= '0;
    end else begin
      beat_cnt    <= beat_next;
      burst_count <= burst_next;
      error_count <= error_next;
      if (accept) begin
        exp_data <= s_axi_data + 1'b1;
      end
      if (len_err) begin
        err_len <= 1'b1;
      end
      if (data_err) begin
        err_data <= 1'b1;
        if (!err_data) begin
          err_expected <= exp_data;
          err_actual   <= s_axi_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_chk.sv
// Self-checking bench for decode_chk: directed scenarios followed by
// randomized bursts, compared against a behavioural stream model.
// Works with or without DECODE_CHK_BP_EN defined.
module tb_decode_chk;

  localparam int MIN_B = 1;
  localparam int MAX_B = 32;
  localparam int CNT_W = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [63:0] data;
  logic        last;
  logic        ready;
  logic [15:0] burst_count;
  logic [15:0] error_count;
  logic        err_data;
  logic        err_len;
  logic [63:0] err_expected;
  logic [63:0] err_actual;

  int check_count = 0;
  int pass_count  = 0;

  // Behavioural model of the stream rules.
  bit          m_synced;
  logic [63:0] m_exp;
  int          m_beats;
  bit          m_overrun;
  int          m_bursts;
  int          m_errors;
  bit          m_err_data;
  bit          m_err_len;
  logic [63:0] m_cap_exp;
  logic [63:0] m_cap_act;
  bit          m_ready;

  always #5 clk = ~clk;

  decode_chk #(
    .MIN_BEATS(MIN_B),
    .MAX_BEATS(MAX_B),
    .CNT_W    (CNT_W),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_axi_valid (valid),
    .s_axi_data  (data),
    .s_axi_last  (last),
    .s_axi_ready (ready),
    .burst_count (burst_count),
    .error_count (error_count),
    .err_data    (err_data),
    .err_len     (err_len),
    .err_expected(err_expected),
    .err_actual  (err_actual)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_count++;
    if (observed === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic modelReset();
    m_synced   = 0;
    m_exp      = '0;
    m_beats    = 0;
    m_overrun  = 0;
    m_bursts   = 0;
    m_errors   = 0;
    m_err_data = 0;
    m_err_len  = 0;
    m_cap_exp  = '0;
    m_cap_act  = '0;
    m_ready    = 0;
  endtask

  task automatic modelBeat(input logic [63:0] d, input bit l);
    int errs;
    errs = 0;
    if (m_synced && d != m_exp) begin
      errs++;
      if (!m_err_data) begin
        m_cap_exp = m_exp;
        m_cap_act = d;
      end
      m_err_data = 1;
    end
    m_exp    = d + 64'd1;
    m_synced = 1;
    m_beats++;
    if (l) begin
      if ((m_beats < MIN_B || m_beats > MAX_B) && !m_overrun) begin
        errs++;
        m_err_len = 1;
      end
      m_bursts  = sat(m_bursts + 1);
      m_beats   = 0;
      m_overrun = 0;
    end else if (m_beats > MAX_B && !m_overrun) begin
      m_overrun = 1;
      m_err_len = 1;
      errs++;
    end
    m_errors = sat(m_errors + errs);
  endtask

  // One clock cycle: drive at negedge, update model and compare after posedge.
  task automatic applyStimulus(input bit v, input logic [63:0] d, input bit l, input bit rst,
                               output bit accepted);
    bit acc_ready;
    @(negedge clk);
    reset = rst;
    valid = v;
    data  = d;
    last  = l;
`ifdef DECODE_CHK_BP_EN
    acc_ready = ready;
`else
    acc_ready = m_ready;
`endif
    accepted = v && acc_ready && !rst;
    @(posedge clk);
    #1;
    if (rst) begin
      modelReset();
    end else begin
      if (accepted) modelBeat(d, l);
      m_ready = 1;
    end
`ifdef DECODE_CHK_BP_EN
    if (rst) checkOutput("ready_reset", 64'(ready), 64'd0);
`else
    checkOutput("ready", 64'(ready), 64'(m_ready));
`endif
    checkOutput("burst_count", 64'(burst_count), 64'(m_bursts));
    checkOutput("error_count", 64'(error_count), 64'(m_errors));
    checkOutput("err_data", 64'(err_data), 64'(m_err_data));
    checkOutput("err_len", 64'(err_len), 64'(m_err_len));
    checkOutput("err_expected", err_expected, m_cap_exp);
    checkOutput("err_actual", err_actual, m_cap_act);
  endtask

  // Present one beat until accepted, bounded by a cycle budget.
  task automatic sendBeat(input logic [63:0] d, input bit l);
    bit acc;
    acc = 0;
    for (int t = 0; t < 64 && !acc; t++) begin
      applyStimulus(1'b1, d, l, 1'b0, acc);
    end
    if (!acc) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic sendBurst(input logic [63:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      sendBeat(start + 64'(i), (i == n - 1));
    end
  endtask

  task automatic doReset();
    bit acc;
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b1, acc);
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b1, acc);
  endtask

  initial begin
    bit          acc;
    int          n;
    logic [63:0] next_d;
    reset = 1'b1;
    valid = 1'b0;
    data  = '0;
    last  = 1'b0;
    modelReset();

    // 1: single 7-beat burst
    doReset();
    checkOutput("reset_errors", 64'(error_count), 64'd0);
    sendBurst(64'd1, 7);
    checkOutput("t1_bursts", 64'(burst_count), 64'd1);
    checkOutput("t1_errors", 64'(error_count), 64'd0);

    // 2: 7 then 26 beats, continuous data
    sendBurst(64'd8, 26);
    checkOutput("t2_bursts", 64'(burst_count), 64'd2);
    checkOutput("t2_errors", 64'(error_count), 64'd0);

    // 3: corrupted beat 4, resync to received value
    doReset();
    sendBeat(64'd1, 0); sendBeat(64'd2, 0); sendBeat(64'd3, 0);
    sendBeat(64'd9, 0); sendBeat(64'd5, 0); sendBeat(64'd6, 0); sendBeat(64'd7, 1);
    checkOutput("t3_err_data", 64'(err_data), 64'd1);
    checkOutput("t3_expected", err_expected, 64'd4);
    checkOutput("t3_actual", err_actual, 64'd9);
    checkOutput("t3_errors", 64'(error_count), 64'd2);

    // 4: 34-beat burst overruns once, then a legal 5-beat burst
    doReset();
    sendBurst(64'd100, 34);
    checkOutput("t4_err_len", 64'(err_len), 64'd1);
    checkOutput("t4_errors", 64'(error_count), 64'd1);
    sendBurst(64'd134, 5);
    checkOutput("t4_bursts", 64'(burst_count), 64'd2);
    checkOutput("t4_errors2", 64'(error_count), 64'd1);

    // 5: payload wraps through all-ones to zero
    doReset();
    sendBurst(64'hFFFF_FFFF_FFFF_FFFE, 4);
    checkOutput("t5_errors", 64'(error_count), 64'd0);

    // 6: reset mid-burst, then resync without error
    doReset();
    sendBeat(64'd50, 0); sendBeat(64'd51, 0); sendBeat(64'd52, 0);
    applyStimulus(1'b1, 64'd53, 1'b0, 1'b1, acc);
    checkOutput("t6_ready", 64'(ready), 64'd0);
    checkOutput("t6_bursts", 64'(burst_count), 64'd0);
    sendBurst(64'd1000, 5);
    checkOutput("t6_errors", 64'(error_count), 64'd0);
    checkOutput("t6_bursts2", 64'(burst_count), 64'd1);

    // Randomized bursts: gaps, corruptions, odd lengths, occasional reset
    next_d = 64'($urandom) << 32 | 64'($urandom);
    for (int b = 0; b < 250; b++) begin
      n = ($urandom_range(0, 9) == 0) ? $urandom_range(30, 36) : $urandom_range(1, 12);
      if ($urandom_range(0, 60) == 0) doReset();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          applyStimulus(1'b0, 64'($urandom), 1'($urandom), 1'b0, acc);
        end
        if ($urandom_range(0, 30) == 0) next_d = next_d ^ 64'($urandom_range(1, 255));
        sendBeat(next_d, (i == n - 1));
        next_d = next_d + 64'd1;
      end
    end

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
